// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS core: load-use stalls, taken-branch flushes,
// MDU interlock and a saturating stall counter. The MDU interlock is built only when HAZARD_MDU_EN is defined.
module hazard_controller #(
  parameter int MDU_LATENCY = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_id_valid,
  input  logic [4:0]             i_id_rs,
  input  logic [4:0]             i_id_rt,
  input  logic                   i_id_uses_rt,
  input  logic                   i_id_mdu_start,
  input  logic                   i_id_mdu_read,
  input  logic                   i_ex_mem_read,
  input  logic [4:0]             i_ex_rt,
  input  logic                   i_ex_branch_taken,
  output logic                   o_pc_write,
  output logic                   o_if_id_write,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_flush,
  output logic                   o_mdu_busy,
  output logic                   o_mdu_done,
  output logic [STALL_CNT_W-1:0] o_stall_cycles
);

  logic load_use;
  logic mdu_haz;
  logic stall;

  assign load_use = i_id_valid && i_ex_mem_read && (i_ex_rt != 5'd0) &&
                    ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  // A taken branch squashes whatever sits in ID, so it cancels any stall.
  assign stall         = (load_use || mdu_haz) && !i_ex_branch_taken;
  assign o_pc_write    = !stall;
  assign o_if_id_write = !stall;
  assign o_if_id_flush = i_ex_branch_taken;
  assign o_id_ex_flush = i_ex_branch_taken || stall;

`ifdef HAZARD_MDU_EN
  localparam int CW = $clog2(MDU_LATENCY + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          issue;

  assign mdu_haz    = i_id_valid && o_mdu_busy && (i_id_mdu_start || i_id_mdu_read);
  assign issue      = i_id_valid && i_id_mdu_start && !i_ex_branch_taken && !stall;
  assign o_mdu_busy = (cnt != '0);
  assign o_mdu_done = (cnt == CW'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          state <= BUSY;
          cnt   <= CW'(MDU_LATENCY);
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
`else
  logic unused_mdu;
  assign unused_mdu = ^{i_id_mdu_start, i_id_mdu_read, 8'(MDU_LATENCY)};
  assign mdu_haz    = 1'b0;
  assign o_mdu_busy = 1'b0;
  assign o_mdu_done = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_stall_cycles <= '0;
    else if (!o_pc_write && !(&o_stall_cycles))
      o_stall_cycles <= o_stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: vector table, hand sequences and random stimulus against a cycle model.
module tb_hazard_controller;

  localparam int LAT = 4;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       start;
    logic       read;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       br;
    logic       rst;
  } in_t;

  typedef struct {
    in_t        in;
    logic [3:0] exp_ctl;
  } vec_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_uses_rt, id_mdu_start, id_mdu_read, ex_mem_read, ex_branch_taken;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy, mdu_done;
  logic [15:0] stall_cycles;
  logic pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s, mdu_busy_s, mdu_done_s;
  logic [1:0] stall_cycles_s;

  always #5 clk = ~clk;

  hazard_controller #(.MDU_LATENCY(LAT), .STALL_CNT_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(id_uses_rt), .i_id_mdu_start(id_mdu_start), .i_id_mdu_read(id_mdu_read),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(ex_branch_taken),
    .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
    .o_id_ex_flush(id_ex_flush), .o_mdu_busy(mdu_busy), .o_mdu_done(mdu_done),
    .o_stall_cycles(stall_cycles));

  hazard_controller #(.MDU_LATENCY(LAT), .STALL_CNT_W(2)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(id_uses_rt), .i_id_mdu_start(id_mdu_start), .i_id_mdu_read(id_mdu_read),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(ex_branch_taken),
    .o_pc_write(pc_write_s), .o_if_id_write(if_id_write_s), .o_if_id_flush(if_id_flush_s),
    .o_id_ex_flush(id_ex_flush_s), .o_mdu_busy(mdu_busy_s), .o_mdu_done(mdu_done_s),
    .o_stall_cycles(stall_cycles_s));

  int n_chk = 0;
  int n_fail = 0;

  // reference model state: cycles of MDU work left, and the two stall tallies
  int m_rem = 0;
  int m_cnt = 0;
  int m_sat = 0;

  // values observed at the last checked cycle
  logic [3:0]  obs_ctl;
  logic        obs_busy, obs_done;
  logic [15:0] obs_cnt;
  logic [1:0]  obs_sat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t v);
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
    id_mdu_start = v.start; id_mdu_read = v.read; ex_mem_read = v.ex_mem_read;
    ex_rt = v.ex_rt; ex_branch_taken = v.br;
  endtask

  // One clock: apply inputs, check all outputs mid-cycle, advance the model.
  task automatic drive(input in_t v);
    bit lu, mh, st;
    logic [3:0] ectl;
    apply(v);
    @(negedge clk);
    lu = v.valid && v.ex_mem_read && v.ex_rt != 0 &&
         (v.ex_rt == v.rs || (v.uses_rt && v.ex_rt == v.rt));
    mh = MDU_EN && v.valid && m_rem > 0 && (v.start || v.read);
    st = (lu || mh) && !v.br;
    ectl = {!st, !st, v.br, v.br || st};
    obs_ctl  = {pc_write, if_id_write, if_id_flush, id_ex_flush};
    obs_busy = mdu_busy; obs_done = mdu_done; obs_cnt = stall_cycles; obs_sat = stall_cycles_s;
    chk("ctl", 64'(obs_ctl), 64'(ectl));
    chk("mdu", 64'({obs_busy, obs_done}), 64'({m_rem > 0, m_rem == 1}));
    chk("stall_cnt", 64'(obs_cnt), 64'(m_cnt));
    chk("sat_inst", 64'({pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s,
                          mdu_busy_s, mdu_done_s, obs_sat}),
        64'({ectl, m_rem > 0, m_rem == 1, 2'(m_sat)}));
    if (v.rst) begin
      m_rem = 0; m_cnt = 0; m_sat = 0;
    end else begin
      if (m_rem > 0) m_rem--;
      else if (MDU_EN && v.valid && v.start && !v.br && !st) m_rem = LAT;
      if (st) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_sat < 3) m_sat++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic in_t mk(input bit valid, input int rs, input int rt, input bit uses_rt,
                             input bit start, input bit read, input bit mr, input int ert,
                             input bit br, input bit r);
    in_t v;
    v.valid = valid; v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses_rt; v.start = start;
    v.read = read; v.ex_mem_read = mr; v.ex_rt = 5'(ert); v.br = br; v.rst = r;
    return v;
  endfunction

  in_t idle, rst_v, lu_v;
  vec_t vecs[10];

  initial begin
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lu_v  = mk(1, 5, 2, 0, 0, 0, 1, 5, 0, 0);
    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush}
    vecs[0] = '{idle, 4'b1100};
    vecs[1] = '{lu_v, 4'b0001};
    vecs[2] = '{mk(1, 0, 2, 0, 0, 0, 1, 0, 0, 0), 4'b1100};
    vecs[3] = '{mk(1, 1, 7, 0, 0, 0, 1, 7, 0, 0), 4'b1100};
    vecs[4] = '{mk(1, 1, 7, 1, 0, 0, 1, 7, 0, 0), 4'b0001};
    vecs[5] = '{mk(1, 5, 2, 0, 0, 0, 1, 5, 1, 0), 4'b1111};
    vecs[6] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 4'b1111};
    vecs[7] = '{mk(0, 5, 5, 1, 0, 0, 1, 5, 0, 0), 4'b1100};
    vecs[8] = '{mk(1, 5, 5, 1, 0, 0, 0, 5, 0, 0), 4'b1100};
    vecs[9] = '{mk(1, 3, 3, 1, 0, 1, 0, 0, 0, 0), 4'b1100};

    apply(rst_v);
    @(posedge clk);
    #1;

    // reset state with all inputs low
    drive(idle);
    chk("reset_ctl", 64'(obs_ctl), 64'(4'b1100));
    chk("reset_cnt", 64'({obs_busy, obs_done, obs_cnt}), 64'(0));

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      chk($sformatf("vec%0d", i), 64'(obs_ctl), 64'(vecs[i].exp_ctl));
    end

    // load-use stall lasts one cycle and counts once
    drive(rst_v);
    drive(lu_v);
    drive(mk(1, 6, 2, 0, 0, 0, 0, 0, 0, 0));
    chk("lu_release", 64'({obs_ctl, obs_cnt}), 64'({4'b1100, 16'd1}));

    // branch in the same cycle as a load-use hazard leaves the counter alone
    drive(mk(1, 5, 2, 0, 0, 0, 1, 5, 1, 0));
    drive(idle);
    chk("br_cnt", 64'(obs_cnt), 64'(1));

`ifdef HAZARD_MDU_EN
    begin
      int stalls, dones;
      bit left;
      drive(rst_v);
      drive(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      stalls = 0; dones = 0; left = 0;
      for (int k = 0; k < 20 && !left; k++) begin
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        if (obs_ctl[3]) left = 1;
        else begin
          stalls++;
          if (obs_done) dones++;
        end
      end
      chk("mflo_left", 64'(left), 64'(1));
      chk("mflo_stalls", 64'(stalls), 64'(LAT));
      chk("mflo_done", 64'(dones), 64'(1));
      chk("mflo_cnt", 64'(obs_cnt), 64'(LAT));

      // reset while two cycles of MDU work remain
      drive(rst_v);
      drive(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      drive(idle);
      drive(idle);
      chk("pre_rst_busy", 64'(obs_busy), 64'(1));
      drive(rst_v);
      drive(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      chk("post_rst", 64'({obs_busy, obs_done, obs_ctl, obs_cnt}), 64'({2'b00, 4'b1100, 16'd0}));
      drive(idle);
      chk("reissue_busy", 64'({obs_busy, obs_done}), 64'(2'b10));
      for (int k = 0; k < LAT; k++) drive(idle);
    end
`else
    drive(rst_v);
    drive(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    chk("mdu_off", 64'({obs_busy, obs_done, obs_ctl}), 64'({2'b00, 4'b1100}));
`endif

    // saturation of the 2-bit counter after five stall cycles
    drive(rst_v);
    for (int k = 0; k < 5; k++) drive(lu_v);
    drive(idle);
    chk("sat3", 64'({obs_sat, obs_cnt}), 64'({2'd3, 16'd5}));

    // random traffic over a small register range so matches are frequent
    for (int k = 0; k < 400; k++) begin
      in_t v;
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
             $urandom_range(0, 60) == 0);
      drive(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register controls. It resolves three hazards that EX-stage forwarding cannot cover: load-use stalls, taken-branch flushes, and interlocks against the multi-cycle multiply/divide unit (MDU). It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MDU_LATENCY, 32, cycles from MDU issue until HI/LO is written; legal range 2..255.
- STALL_CNT_W, 32, width of the stall performance counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_id_valid  in  1  ID holds a real instruction (not a bubble).
- i_id_rs  in  5  rs of the instruction in ID.
- i_id_rt  in  5  rt of the instruction in ID.
- i_id_uses_rt  in  1  the ID instruction reads rt as a source.
- i_id_mdu_start  in  1  the ID instruction is mult/multu/div/divu.
- i_id_mdu_read  in  1  the ID instruction is mfhi/mflo.
- i_ex_mem_read  in  1  the EX instruction is a load.
- i_ex_rt  in  5  destination register of the load in EX.
- i_ex_branch_taken  in  1  the branch/jump resolved in EX is taken.
- o_pc_write  out  1  PC update enable.
- o_if_id_write  out  1  IF/ID register enable.
- o_if_id_flush  out  1  clear IF/ID to a bubble.
- o_id_ex_flush  out  1  insert a bubble into ID/EX.
- o_mdu_busy  out  1  an MDU operation is in flight.
- o_mdu_done  out  1  single-cycle pulse; HI/LO is written at the end of this cycle.
- o_stall_cycles  out  STALL_CNT_W  count of cycles with o_pc_write=0.

## Operation
- Load-use hazard (combinational): i_id_valid && i_ex_mem_read && i_ex_rt!=0 && (i_ex_rt==i_id_rs || (i_id_uses_rt && i_ex_rt==i_id_rt)).
- MDU hazard (combinational): i_id_valid && o_mdu_busy && (i_id_mdu_start || i_id_mdu_read).
- Priority: branch flush > MDU hazard > load-use hazard.
- Branch taken: o_if_id_flush=1, o_id_ex_flush=1, o_pc_write=1, o_if_id_write=1. Any stall condition is cancelled for that cycle.
- Stall (either hazard, no branch): o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1, o_if_id_flush=0.
- Otherwise: o_pc_write=1, o_if_id_write=1, both flushes 0.
- MDU FSM has two states, IDLE and BUSY, backed by a down-counter cnt of width clog2(MDU_LATENCY+1).
  - Issue = i_id_valid && i_id_mdu_start && no branch flush && no stall.
  - IDLE→BUSY on issue, with cnt loaded to MDU_LATENCY.
  - In BUSY, cnt decrements each cycle. BUSY→IDLE when cnt==1, with cnt becoming 0.
  - o_mdu_busy = (cnt!=0). o_mdu_done = (cnt==1).
  - A taken branch does not abort an in-flight MDU op. A flushed mdu_start is never issued.
- Stall counter: increments every cycle with o_pc_write=0 and saturates at all-ones (never wraps).
- Reset values: FSM=IDLE, cnt=0, o_mdu_busy=0, o_mdu_done=0, o_stall_cycles=0. With all inputs 0, o_pc_write=1, o_if_id_write=1, and both flushes=0.

## Timing
- Hazard and flush outputs are combinational from the inputs and state, valid in the same cycle.
- MDU issue accepted in cycle N → o_mdu_busy high in cycles N+1..N+MDU_LATENCY.
  - o_mdu_done is high only in cycle N+MDU_LATENCY.
  - The first cycle a dependent mfhi/mflo or a new mult/div may leave ID is N+MDU_LATENCY+1.
- Reading HI/LO during the done cycle stalls for one cycle, because busy is still 1.
- Load-use stall lasts exactly one cycle. In the next cycle the load is in MEM, the ID/EX bubble sits in EX, and no hazard remains.
- Reset asserted mid-MDU-operation: the next cycle is IDLE with busy=0, and no done pulse is emitted.
- Reset has priority over every other event in the same cycle.

## Configuration
- HAZARD_MDU_EN defined: the MDU FSM, counter and MDU hazard are present as described.
- HAZARD_MDU_EN undefined:
  - i_id_mdu_start and i_id_mdu_read are ignored.
  - o_mdu_busy and o_mdu_done are tied to 0.
  - No counter or FSM is synthesized.
  - Only load-use and branch logic remain, and the stall counter still counts load-use stalls.

## Test plan
- Load-use: EX lw with i_ex_rt=5, ID rs=5 → one cycle of o_pc_write=0, o_id_ex_flush=1, o_stall_cycles=1. Same stimulus with i_ex_rt=0 → no stall.
- rt check: ID rt=7 and EX load rt=7 with i_id_uses_rt=0 → no stall. With i_id_uses_rt=1 → stall.
- MDU, MDU_LATENCY=4: issue mult at cycle 10 → busy high in cycles 11-14, done only in cycle 14. An mflo held in ID from cycle 11 stalls in cycles 11-14 and issues in cycle 15; o_stall_cycles=4.
- Branch versus stall: load-use hazard and i_ex_branch_taken=1 in the same cycle → o_if_id_flush=1, o_id_ex_flush=1, o_pc_write=1, stall counter unchanged.
- Reset mid-op: assert i_reset at cnt=2 → next cycle busy=0, done never pulses, counters 0. A new mult then issues immediately without a stall.
- Saturation with STALL_CNT_W=2: 5 consecutive stall cycles → o_stall_cycles stays at 3.
